// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer with baud-generator gating
// Optional second stop bit: define UART_TX_STOP2_EN.
module uart_tx_ctrl #(
  parameter int DataBits = 8
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic [DataBits-1:0] DataIn,
  input  logic                Send,
  input  logic [1:0]          ParityType,
  output logic                Ready,
  input  logic                BaudTick,
  output logic                BaudEnable,
  output logic                BaudSyncN,
  output logic                TxOut,
  output logic                Busy,
  output logic                Done
);

  localparam int CntW = $clog2(DataBits);
  localparam logic [CntW-1:0] LastBit = CntW'(DataBits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_STOP2_EN
    STOP2,
`endif
    STOP
  } state_t;

  state_t              state;
  logic [DataBits-1:0] shreg;
  logic [CntW-1:0]     bit_cnt;
  logic                par_bit;
  logic                par_en;
  logic                tick;
  logic                data_xor;

  // The tick landing while the baud counter is being cleared belongs to the old period.
  assign tick     = BaudTick & BaudSyncN;
  assign data_xor = ^DataIn;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      par_en     <= 1'b0;
      TxOut      <= 1'b1;
      Ready      <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      BaudEnable <= 1'b0;
      BaudSyncN  <= 1'b1;
    end else begin
      Done      <= 1'b0;
      BaudSyncN <= 1'b1;
      case (state)
        IDLE: begin
          if (Send && Ready) begin
            shreg      <= DataIn;
            par_en     <= ParityType[0] ^ ParityType[1];
            par_bit    <= (ParityType == 2'b01) ? ~data_xor : data_xor;
            bit_cnt    <= '0;
            TxOut      <= 1'b0;
            Ready      <= 1'b0;
            Busy       <= 1'b1;
            BaudEnable <= 1'b1;
            BaudSyncN  <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (tick) begin
            TxOut   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt != LastBit) begin
              bit_cnt <= bit_cnt + 1'b1;
              TxOut   <= shreg[0];
              shreg   <= shreg >> 1;
            end else if (par_en) begin
              TxOut <= par_bit;
              state <= PARITY;
            end else begin
              TxOut <= 1'b1;
              state <= STOP;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            TxOut <= 1'b1;
            state <= STOP;
          end
        end
`ifdef UART_TX_STOP2_EN
        STOP: begin
          if (tick) begin
            state <= STOP2;
          end
        end
        STOP2: begin
          if (tick) begin
            Done       <= 1'b1;
            Busy       <= 1'b0;
            Ready      <= 1'b1;
            BaudEnable <= 1'b0;
            state      <= IDLE;
          end
        end
`else
        STOP: begin
          if (tick) begin
            Done       <= 1'b1;
            Busy       <= 1'b0;
            Ready      <= 1'b1;
            BaudEnable <= 1'b0;
            state      <= IDLE;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

`ifdef UART_TX_STOP2_EN
  localparam int Stops = 2;
`else
  localparam int Stops = 1;
`endif

  logic       Clock;
  logic       ResetN;
  logic [7:0] DataIn;
  logic       Send;
  logic [1:0] ParityType;
  logic       Ready;
  logic       BaudTick;
  logic       BaudEnable;
  logic       BaudSyncN;
  logic       TxOut;
  logic       Busy;
  logic       Done;

  logic [4:0] DataIn5;
  logic       Send5;
  logic [1:0] ParityType5;
  logic       Ready5;
  logic       BaudTick5;
  logic       BaudEnable5;
  logic       BaudSyncN5;
  logic       TxOut5;
  logic       Busy5;
  logic       Done5;

  uart_tx_ctrl #(.DataBits(8)) u_dut (
    .Clock(Clock), .ResetN(ResetN), .DataIn(DataIn), .Send(Send),
    .ParityType(ParityType), .Ready(Ready), .BaudTick(BaudTick),
    .BaudEnable(BaudEnable), .BaudSyncN(BaudSyncN), .TxOut(TxOut),
    .Busy(Busy), .Done(Done)
  );

  uart_tx_ctrl #(.DataBits(5)) u_dut5 (
    .Clock(Clock), .ResetN(ResetN), .DataIn(DataIn5), .Send(Send5),
    .ParityType(ParityType5), .Ready(Ready5), .BaudTick(BaudTick5),
    .BaudEnable(BaudEnable5), .BaudSyncN(BaudSyncN5), .TxOut(TxOut5),
    .Busy(Busy5), .Done(Done5)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pt;
    int          nbits;
    logic [15:0] exp;
    bit          sync_tick;
    int          poke_at;
  } vec_t;

  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;
  int   bcnt   = 0;
  int   bcnt5  = 0;
  bit   force_tick = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Baud generator stand-in: divide by 4, cleared while disabled or synced.
  task automatic step();
    @(negedge Clock);
    if (!BaudEnable || !BaudSyncN) bcnt = 0; else bcnt = (bcnt + 1) % 4;
    BaudTick = (BaudEnable && BaudSyncN && bcnt == 3) || force_tick;
    if (!BaudEnable5 || !BaudSyncN5) bcnt5 = 0; else bcnt5 = (bcnt5 + 1) % 4;
    BaudTick5 = (BaudEnable5 && BaudSyncN5 && bcnt5 == 3) || force_tick;
  endtask

  task automatic capture(input bit sel, input bit hold, input logic [7:0] nd,
                         input logic [1:0] np, input bit sync_tick, input int poke_at,
                         output logic [63:0] smp, output int len);
    int sync_low;
    int busy_low;
    bit seen;
    sync_low = 0;
    busy_low = 0;
    seen     = 0;
    smp      = '0;
    len      = 0;
    for (int c = 0; c < 300; c++) begin
      force_tick = sync_tick && (c == 0);
      step();
      force_tick = 0;
      if (sel ? Done5 : Done) begin
        seen = 1;
        break;
      end
      if (c == 0) begin
        if (hold) begin
          DataIn     = nd;
          ParityType = np;
        end else begin
          Send  = 1'b0;
          Send5 = 1'b0;
        end
      end
      if (poke_at > 0 && c == poke_at) begin
        chk("ready_low_midframe", Ready, 1'b0);
        DataIn = 8'hFF;
        Send   = 1'b1;
      end
      if (poke_at > 0 && c == poke_at + 1) Send = 1'b0;
      if (len < 64) smp[len] = sel ? TxOut5 : TxOut;
      len++;
      if (!(sel ? BaudSyncN5 : BaudSyncN)) sync_low++;
      if (!(sel ? Busy5 : Busy)) busy_low++;
    end
    chk("done_seen", seen, 1'b1);
    chk("sync_low_cycles", sync_low, 1);
    chk("busy_held", busy_low, 0);
  endtask

  task automatic check_frame(input string name, input logic [63:0] smp, input int len,
                             input int nbits, input logic [15:0] exp);
    int          n;
    logic [15:0] want;
    logic [15:0] got;
    n    = nbits + Stops;
    want = exp;
    got  = '0;
    for (int k = nbits; k < n; k++) want[k] = 1'b1;
    for (int k = 0; k < n; k++) got[k] = smp[4*k+1];
    chk({name, "_bits"}, got, want);
    chk({name, "_len"}, len, 4 * n);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [63:0] smp;
    int          len;
    step();
    DataIn     = v.data;
    ParityType = v.pt;
    Send       = 1'b1;
    @(posedge Clock);
    capture(1'b0, 1'b0, 8'h00, 2'b00, v.sync_tick, v.poke_at, smp, len);
    check_frame(name, smp, len, v.nbits, v.exp);
    chk({name, "_ready_at_done"}, Ready, 1'b1);
    step();
    chk({name, "_done_pulse"}, Done, 1'b0);
    repeat (3) step();
    chk({name, "_idle_after"}, {Busy, TxOut, Ready}, 3'b011);
  endtask

  initial begin
    logic [63:0] smp;
    int          len;

    vecs[0] = '{8'hA5, 2'b00,  9, 16'h014A, 1'b0,  0};
    vecs[1] = '{8'hA5, 2'b10, 10, 16'h014A, 1'b1,  0};
    vecs[2] = '{8'hA5, 2'b01, 10, 16'h034A, 1'b0,  0};
    vecs[3] = '{8'h3C, 2'b01, 10, 16'h0278, 1'b0,  0};
    vecs[4] = '{8'h01, 2'b11,  9, 16'h0002, 1'b0,  0};
    vecs[5] = '{8'hA5, 2'b00,  9, 16'h014A, 1'b0, 10};

    ResetN      = 1'b0;
    DataIn      = '0;
    Send        = 1'b0;
    ParityType  = '0;
    BaudTick    = 1'b0;
    DataIn5     = '0;
    Send5       = 1'b0;
    ParityType5 = '0;
    BaudTick5   = 1'b0;

    repeat (3) step();
    chk("reset_state", {TxOut, Ready, Busy, Done, BaudEnable, BaudSyncN}, 6'b110001);
    ResetN = 1'b1;
    step();
    chk("post_reset_idle", {TxOut, Ready, Busy, Done, BaudEnable, BaudSyncN}, 6'b110001);

    force_tick = 1;
    repeat (4) step();
    force_tick = 0;
    step();
    chk("idle_tick_ignored", {TxOut, Ready, Busy, BaudEnable}, 4'b1100);

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    step();
    DataIn     = 8'h00;
    ParityType = 2'b00;
    Send       = 1'b1;
    @(posedge Clock);
    capture(1'b0, 1'b1, 8'hFF, 2'b10, 1'b0, 0, smp, len);
    check_frame("b2b_first", smp, len, 9, 16'h0000);
    chk("b2b_ready_at_done", Ready, 1'b1);
    @(posedge Clock);
    capture(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 0, smp, len);
    check_frame("b2b_second", smp, len, 10, 16'h01FE);
    step();
    chk("b2b_done_pulse", Done, 1'b0);

    step();
    DataIn5     = 5'h13;
    ParityType5 = 2'b00;
    Send5       = 1'b1;
    @(posedge Clock);
    capture(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 0, smp, len);
    check_frame("dbits5", smp, len, 6, 16'h0026);
    step();
    chk("dbits5_done_pulse", Done5, 1'b0);

    step();
    DataIn     = 8'h00;
    ParityType = 2'b00;
    Send       = 1'b1;
    @(posedge Clock);
    step();
    Send = 1'b0;
    repeat (10) step();
    chk("mid_data_state", {TxOut, Busy, Ready}, 3'b010);
    #3;
    ResetN = 1'b0;
    #1;
    chk("async_reset", {TxOut, Ready, Busy, BaudEnable, Done, BaudSyncN}, 6'b110001);
    repeat (2) step();
    ResetN = 1'b1;
    step();
    chk("after_abort_idle", {TxOut, Ready, Busy}, 3'b110);
    run_vec("recover", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
